// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with per-register rename tags
module reg_file_rename #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int NO_RENAME  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  jump_wrong,
  input  logic                  enable_reg,
  input  logic [4:0]            to_reg_rd,
  input  logic [DATA_WIDTH-1:0] to_reg_value,
  input  logic [TAG_WIDTH-1:0]  to_reg_rename,
  input  logic                  decoder_rename_enable,
  input  logic [4:0]            decoder_rd,
  input  logic [TAG_WIDTH-1:0]  decoder_rd_rename,
  input  logic [4:0]            decoder_rs1,
  input  logic [4:0]            decoder_rs2,
  output logic [DATA_WIDTH-1:0] rs1_value,
  output logic [TAG_WIDTH-1:0]  rs1_rename,
  output logic [DATA_WIDTH-1:0] rs2_value,
  output logic [TAG_WIDTH-1:0]  rs2_rename,
  output logic [5:0]            renamed_count
);

  localparam logic [TAG_WIDTH-1:0] NR = TAG_WIDTH'(NO_RENAME);

  logic [DATA_WIDTH-1:0] value_q [REG_NUM];
  logic [TAG_WIDTH-1:0]  tag_q   [REG_NUM];

  logic                  commit_en;
  logic                  rename_en;
  logic [TAG_WIDTH-1:0]  commit_old_tag;
  logic [TAG_WIDTH-1:0]  rename_old_tag;
  logic                  commit_clear;
  logic                  inc_rename;
  logic                  dec_rename;
  logic                  dec_commit;
  logic [6:0]            count_sum;
  logic [6:0]            count_dec;
  logic [6:0]            count_diff;
  logic [5:0]            count_next;

  // Decode commit/rename qualifiers and the bookkeeping delta for renamed_count.
  // A rename of the committing register in the same cycle keeps the new tag, so
  // the commit's tag clear is suppressed and no decrement is taken for it.
  always_comb begin
    commit_en      = rdy && enable_reg && (to_reg_rd != 5'd0);
    rename_en      = rdy && decoder_rename_enable && (decoder_rd != 5'd0) && !jump_wrong;
    commit_old_tag = tag_q[to_reg_rd];
    rename_old_tag = tag_q[decoder_rd];
    commit_clear   = commit_en && (commit_old_tag == to_reg_rename)
                     && !(rename_en && (decoder_rd == to_reg_rd));
    inc_rename     = rename_en && (rename_old_tag == NR) && (decoder_rd_rename != NR);
    dec_rename     = rename_en && (rename_old_tag != NR) && (decoder_rd_rename == NR);
    dec_commit     = commit_clear && (commit_old_tag != NR);
    count_sum      = {1'b0, renamed_count} + {6'd0, inc_rename};
    count_dec      = {6'd0, dec_rename} + {6'd0, dec_commit};
    count_diff     = count_sum - count_dec;
    if (count_sum < count_dec) begin
      count_next = 6'd0;
    end else if (count_diff > 7'd31) begin
      count_next = 6'd31;
    end else begin
      count_next = count_diff[5:0];
    end
  end

  // Source 1 read with same-cycle commit bypass when the commit retires the owning tag.
  always_comb begin
    rs1_value  = value_q[decoder_rs1];
    rs1_rename = tag_q[decoder_rs1];
    if (decoder_rs1 == 5'd0) begin
      rs1_value  = '0;
      rs1_rename = NR;
    end else if (rdy && enable_reg && (to_reg_rd == decoder_rs1)
                 && (to_reg_rename == tag_q[decoder_rs1])) begin
      rs1_value  = to_reg_value;
      rs1_rename = NR;
    end
  end

  // Source 2 read with the same bypass rule as source 1.
  always_comb begin
    rs2_value  = value_q[decoder_rs2];
    rs2_rename = tag_q[decoder_rs2];
    if (decoder_rs2 == 5'd0) begin
      rs2_value  = '0;
      rs2_rename = NR;
    end else if (rdy && enable_reg && (to_reg_rd == decoder_rs2)
                 && (to_reg_rename == tag_q[decoder_rs2])) begin
      rs2_value  = to_reg_value;
      rs2_rename = NR;
    end
  end

  // Register state: reset clears all, flush drops every tag, otherwise commit then rename.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= NR;
      end
      renamed_count <= 6'd0;
    end else if (rdy) begin
      if (commit_en) begin
        value_q[to_reg_rd] <= to_reg_value;
      end
      if (jump_wrong) begin
        for (int i = 0; i < REG_NUM; i++) begin
          tag_q[i] <= NR;
        end
        renamed_count <= 6'd0;
      end else begin
        if (commit_clear) begin
          tag_q[to_reg_rd] <= NR;
        end
        if (rename_en) begin
          tag_q[decoder_rd] <= decoder_rd_rename;
        end
        renamed_count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// tb/tb_reg_file_rename.sv - self-checking bench for reg_file_rename
module tb_reg_file_rename;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jump_wrong;
  logic        enable_reg;
  logic [4:0]  to_reg_rd;
  logic [31:0] to_reg_value;
  logic [4:0]  to_reg_rename;
  logic        decoder_rename_enable;
  logic [4:0]  decoder_rd;
  logic [4:0]  decoder_rd_rename;
  logic [4:0]  decoder_rs1;
  logic [4:0]  decoder_rs2;
  logic [31:0] rs1_value;
  logic [4:0]  rs1_rename;
  logic [31:0] rs2_value;
  logic [4:0]  rs2_rename;
  logic [5:0]  renamed_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_val [32];
  int          m_tag [32];

  reg_file_rename dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
    .jump_wrong            (jump_wrong),
    .enable_reg            (enable_reg),
    .to_reg_rd             (to_reg_rd),
    .to_reg_value          (to_reg_value),
    .to_reg_rename         (to_reg_rename),
    .decoder_rename_enable (decoder_rename_enable),
    .decoder_rd            (decoder_rd),
    .decoder_rd_rename     (decoder_rd_rename),
    .decoder_rs1           (decoder_rs1),
    .decoder_rs2           (decoder_rs2),
    .rs1_value             (rs1_value),
    .rs1_rename            (rs1_rename),
    .rs2_value             (rs2_value),
    .rs2_rename            (rs2_rename),
    .renamed_count         (renamed_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state as plain arrays, updated at each edge.
  task automatic model_update();
    logic cm;
    logic rn;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'd0;
        m_tag[i] = 16;
      end
    end else if (rdy) begin
      cm = enable_reg && (to_reg_rd != 0);
      rn = decoder_rename_enable && (decoder_rd != 0) && !jump_wrong;
      if (cm) begin
        m_val[to_reg_rd] = to_reg_value;
        if (m_tag[to_reg_rd] == int'(to_reg_rename) && !(rn && decoder_rd == to_reg_rd))
          m_tag[to_reg_rd] = 16;
      end
      if (rn) m_tag[decoder_rd] = int'(decoder_rd_rename);
      if (jump_wrong) for (int i = 0; i < 32; i++) m_tag[i] = 16;
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 1; i < 32; i++) if (m_tag[i] != 16) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (rdy && enable_reg && to_reg_rd == rs && int'(to_reg_rename) == m_tag[rs]) return to_reg_value;
    return m_val[rs];
  endfunction

  function automatic logic [4:0] exp_tag(input logic [4:0] rs);
    if (rs == 0) return 5'd16;
    if (rdy && enable_reg && to_reg_rd == rs && int'(to_reg_rename) == m_tag[rs]) return 5'd16;
    return 5'(m_tag[rs]);
  endfunction

  task automatic idle();
    rst = 0; rdy = 1; jump_wrong = 0; enable_reg = 0;
    to_reg_rd = 0; to_reg_value = 0; to_reg_rename = 0;
    decoder_rename_enable = 0; decoder_rd = 0; decoder_rd_rename = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); idle();
    decoder_rs1 = 5; decoder_rs2 = 0; #2;
    checks++; if (rs1_value !== 32'd0) begin errors++; $display("FAIL reset_rs1_value got=%0h exp=0", rs1_value); end
    checks++; if (rs1_rename !== 5'd16) begin errors++; $display("FAIL reset_rs1_rename got=%0d exp=16", rs1_rename); end
    checks++; if (rs2_value !== 32'd0) begin errors++; $display("FAIL reset_rs2_value got=%0h exp=0", rs2_value); end
    checks++; if (rs2_rename !== 5'd16) begin errors++; $display("FAIL reset_rs2_rename got=%0d exp=16", rs2_rename); end
    checks++; if (renamed_count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", renamed_count); end
  endtask

  task automatic test_commit_bypass();
    idle(); decoder_rename_enable = 1; decoder_rd = 5; decoder_rd_rename = 3; tick();
    checks++; if (renamed_count !== 6'd1) begin errors++; $display("FAIL bypass_count_up got=%0d exp=1", renamed_count); end
    idle(); enable_reg = 1; to_reg_rd = 5; to_reg_value = 32'hDEADBEEF; to_reg_rename = 3;
    decoder_rs1 = 5; #2;
    checks++; if (rs1_value !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_value got=%0h exp=deadbeef", rs1_value); end
    checks++; if (rs1_rename !== 5'd16) begin errors++; $display("FAIL bypass_tag got=%0d exp=16", rs1_rename); end
    tick(); idle(); #2;
    checks++; if (rs1_value !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_value got=%0h exp=deadbeef", rs1_value); end
    checks++; if (rs1_rename !== 5'd16) begin errors++; $display("FAIL commit_tag got=%0d exp=16", rs1_rename); end
    checks++; if (renamed_count !== 6'd0) begin errors++; $display("FAIL commit_count got=%0d exp=0", renamed_count); end
  endtask

  task automatic test_stale_commit();
    idle(); decoder_rename_enable = 1; decoder_rd = 7; decoder_rd_rename = 2; tick();
    decoder_rd_rename = 9; tick();
    idle(); enable_reg = 1; to_reg_rd = 7; to_reg_value = 32'h11; to_reg_rename = 2; tick();
    idle(); decoder_rs1 = 7; #2;
    checks++; if (rs1_value !== 32'h11) begin errors++; $display("FAIL stale_value got=%0h exp=11", rs1_value); end
    checks++; if (rs1_rename !== 5'd9) begin errors++; $display("FAIL stale_tag got=%0d exp=9", rs1_rename); end
    checks++; if (renamed_count !== 6'd1) begin errors++; $display("FAIL stale_count got=%0d exp=1", renamed_count); end
  endtask

  task automatic test_same_cycle();
    idle(); decoder_rename_enable = 1; decoder_rd = 4; decoder_rd_rename = 1; tick();
    checks++; if (renamed_count !== 6'd2) begin errors++; $display("FAIL same_pre_count got=%0d exp=2", renamed_count); end
    enable_reg = 1; to_reg_rd = 4; to_reg_value = 32'h55; to_reg_rename = 1; decoder_rd_rename = 6; tick();
    idle(); decoder_rs2 = 4; #2;
    checks++; if (rs2_value !== 32'h55) begin errors++; $display("FAIL same_value got=%0h exp=55", rs2_value); end
    checks++; if (rs2_rename !== 5'd6) begin errors++; $display("FAIL same_tag got=%0d exp=6", rs2_rename); end
    checks++; if (renamed_count !== 6'd2) begin errors++; $display("FAIL same_count got=%0d exp=2", renamed_count); end
  endtask

  task automatic test_flush();
    idle(); decoder_rename_enable = 1;
    for (int i = 1; i <= 3; i++) begin decoder_rd = 5'(i); decoder_rd_rename = 5'(i - 1); tick(); end
    checks++; if (renamed_count !== 6'd5) begin errors++; $display("FAIL flush_pre_count got=%0d exp=5", renamed_count); end
    jump_wrong = 1; decoder_rd = 8; decoder_rd_rename = 3;
    enable_reg = 1; to_reg_rd = 1; to_reg_value = 32'h99; to_reg_rename = 0; tick();
    idle(); decoder_rs1 = 1; decoder_rs2 = 8; #2;
    checks++; if (rs1_value !== 32'h99) begin errors++; $display("FAIL flush_value got=%0h exp=99", rs1_value); end
    checks++; if (rs2_rename !== 5'd16) begin errors++; $display("FAIL flush_drop_rename got=%0d exp=16", rs2_rename); end
    checks++; if (renamed_count !== 6'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", renamed_count); end
    for (int i = 1; i < 32; i++) begin
      decoder_rs1 = 5'(i); #1;
      checks++; if (rs1_rename !== 5'd16) begin errors++; $display("FAIL flush_tag_x%0d got=%0d exp=16", i, rs1_rename); end
    end
  endtask

  task automatic test_rdy_reset();
    idle(); decoder_rename_enable = 1; decoder_rd = 10; decoder_rd_rename = 5; tick();
    idle(); rdy = 0; decoder_rename_enable = 1; decoder_rd = 12; decoder_rd_rename = 4;
    enable_reg = 1; to_reg_rd = 10; to_reg_value = 32'hAA; to_reg_rename = 5;
    decoder_rs1 = 10; decoder_rs2 = 12; #2;
    checks++; if (rs1_value !== 32'd0) begin errors++; $display("FAIL hold_no_bypass got=%0h exp=0", rs1_value); end
    checks++; if (rs1_rename !== 5'd5) begin errors++; $display("FAIL hold_live_tag got=%0d exp=5", rs1_rename); end
    tick(); tick(); #1;
    checks++; if (rs1_value !== 32'd0) begin errors++; $display("FAIL hold_value got=%0h exp=0", rs1_value); end
    checks++; if (rs1_rename !== 5'd5) begin errors++; $display("FAIL hold_tag got=%0d exp=5", rs1_rename); end
    checks++; if (rs2_rename !== 5'd16) begin errors++; $display("FAIL hold_rename got=%0d exp=16", rs2_rename); end
    checks++; if (renamed_count !== 6'd1) begin errors++; $display("FAIL hold_count got=%0d exp=1", renamed_count); end
    rst = 1; tick(); idle(); decoder_rs1 = 5; decoder_rs2 = 10; #2;
    checks++; if (rs1_value !== 32'd0) begin errors++; $display("FAIL rst_value got=%0h exp=0", rs1_value); end
    checks++; if (rs2_rename !== 5'd16) begin errors++; $display("FAIL rst_tag got=%0d exp=16", rs2_rename); end
    checks++; if (renamed_count !== 6'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", renamed_count); end
  endtask

  task automatic test_random();
    logic [4:0] c_rd;
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      rdy        = ($urandom_range(0, 7) != 0);
      jump_wrong = ($urandom_range(0, 15) == 0);
      enable_reg = $urandom_range(0, 1);
      c_rd       = 5'($urandom_range(0, 7));
      to_reg_rd  = c_rd;
      to_reg_value = $urandom;
      to_reg_rename = $urandom_range(0, 1) ? 5'(m_tag[c_rd]) : 5'($urandom_range(0, 15));
      decoder_rename_enable = $urandom_range(0, 1);
      decoder_rd  = 5'($urandom_range(0, 7));
      decoder_rd_rename = 5'($urandom_range(0, 15));
      decoder_rs1 = 5'($urandom_range(0, 7));
      decoder_rs2 = 5'($urandom_range(0, 7));
      #2;
      checks++; if (rs1_value !== exp_val(decoder_rs1)) begin errors++; $display("FAIL rnd_rs1_value n=%0d got=%0h exp=%0h", n, rs1_value, exp_val(decoder_rs1)); end
      checks++; if (rs1_rename !== exp_tag(decoder_rs1)) begin errors++; $display("FAIL rnd_rs1_tag n=%0d got=%0d exp=%0d", n, rs1_rename, exp_tag(decoder_rs1)); end
      checks++; if (rs2_value !== exp_val(decoder_rs2)) begin errors++; $display("FAIL rnd_rs2_value n=%0d got=%0h exp=%0h", n, rs2_value, exp_val(decoder_rs2)); end
      checks++; if (rs2_rename !== exp_tag(decoder_rs2)) begin errors++; $display("FAIL rnd_rs2_tag n=%0d got=%0d exp=%0d", n, rs2_rename, exp_tag(decoder_rs2)); end
      tick();
      checks++; if (int'(renamed_count) !== m_count()) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, renamed_count, m_count()); end
    end
  endtask

  initial begin
    idle(); rst = 1; decoder_rs1 = 0; decoder_rs2 = 0;
    for (int i = 0; i < 32; i++) begin m_val[i] = 32'd0; m_tag[i] = 16; end
    #1;
    test_reset();
    test_commit_bypass();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_rdy_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file plus per-register rename table; sits directly downstream of the reorder buffer's commit port and beside the decoder.
- On commit, the ROB writes retired values here.
- On dispatch, the decoder reads source operands (value plus rename tag) and marks the destination register as renamed to its ROB entry.
- A mispredict flush from the ROB clears all rename tags so that the architectural values become authoritative again.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero)
- DATA_WIDTH, 32, register value width
- TAG_WIDTH, 5, rename tag width; bits [3:0] hold the ROB index, bit 4 set means not renamed
- NO_RENAME, 16, tag value meaning "value valid in register file"

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; state holds when low
- jump_wrong  in  1  ROB flush request
- enable_reg  in  1  ROB commit write enable
- to_reg_rd  in  5  commit destination register index
- to_reg_value  in  DATA_WIDTH  commit value
- to_reg_rename  in  TAG_WIDTH  ROB tag of the committing entry
- decoder_rename_enable  in  1  decoder allocates a destination
- decoder_rd  in  5  destination register being renamed
- decoder_rd_rename  in  TAG_WIDTH  ROB tag allocated to the destination
- decoder_rs1  in  5  source 1 index
- decoder_rs2  in  5  source 2 index
- rs1_value  out  DATA_WIDTH  source 1 value (combinational)
- rs1_rename  out  TAG_WIDTH  source 1 tag, NO_RENAME if the value is valid
- rs2_value  out  DATA_WIDTH  source 2 value (combinational)
- rs2_rename  out  TAG_WIDTH  source 2 tag
- renamed_count  out  6  number of registers currently holding a tag, registered

Behaviour:
- State: value[0..31] and tag[0..31].
- Reset (rst=1 at a clock edge, regardless of rdy): all values 0, all tags NO_RENAME, renamed_count 0. After reset, reads return 0 / 16.
- rdy=0: no state change. Read outputs stay live and combinational.
- Commit (rdy=1, enable_reg=1, to_reg_rd!=0):
  - value[rd] <= to_reg_value.
  - tag[rd] <= NO_RENAME only if tag[rd]==to_reg_rename; otherwise the tag is kept, because a younger instruction owns the register.
- Rename (rdy=1, decoder_rename_enable=1, decoder_rd!=0, jump_wrong=0): tag[rd] <= decoder_rd_rename.
- Same cycle, same rd: the commit value is written and rename wins, so tag = new tag. Commit tag-clear is suppressed.
- x0: writes and renames to index 0 are ignored. Reads of x0 return value 0 and tag NO_RENAME.
- Flush (rdy=1, jump_wrong=1):
  - All tags <= NO_RENAME.
  - A commit presented in the same cycle still writes its value.
  - A rename presented in the same cycle is dropped.
  - renamed_count <= 0.
- Read bypass, per source rsN:
  - If enable_reg=1, rdy=1, to_reg_rd==rsN!=0 and to_reg_rename==tag[rsN], output to_reg_value with tag NO_RENAME.
  - Otherwise output value[rsN] and tag[rsN].
  - Reads never reflect a same-cycle rename; the decoder handles rd==rs ordering itself.
- renamed_count:
  - Registered count of tags != NO_RENAME, updated each enabled cycle by +1 for a rename of a previously unrenamed register.
  - −1 for a commit that clears a tag.
  - Net 0 when both affect the same register.
  - Range 0..31, never wraps.
- Latency: writes are visible to reads on the cycle after the edge, or on the same cycle through the bypass.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> rs1_value=0, rs1_rename=16, rs2_value=0, rs2_rename=16, renamed_count=0.
- Rename x5 to tag 3, next cycle commit x5=0xDEADBEEF with tag 3 -> during the commit cycle rs1=5 bypasses 0xDEADBEEF with tag 16; afterwards value=0xDEADBEEF, tag=16, count returns 1->0.
- Rename x7 to tag 2, then x7 to tag 9, commit x7=0x11 with tag 2 -> value 0x11, tag stays 9, count=1.
- Same-cycle commit x4=0x55 (tag 1, matching) and rename x4 to tag 6 -> value 0x55, tag 6, count unchanged.
- Rename x1, x2, x3 to tags 0, 1, 2; assert jump_wrong together with a rename of x8 to tag 3 and a commit of x1=0x99 with tag 0 -> all tags 16, x1=0x99, x8 not renamed, count=0.
- rdy=0 while rename/commit are asserted, then rst=1 mid-sequence -> no state change while rdy=0; reset clears everything on the next edge.
